// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Two's complement magnitude; INT_MIN maps to 0x80000000 read as unsigned.
   function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? (~x + 1'b1) : x;
   endfunction

endpackage

// File: rtl/multdiv_if.sv
// Operand/control/result bundle between the execute stage and the multdiv unit.
interface multdiv_if
   import multdiv_pkg::*;
;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      input  data_result, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      output data_result, data_exception, data_resultRDY, busy
   );
endinterface

// File: rtl/multdiv_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module multdiv_div_step
   import multdiv_pkg::*;
(
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_divisor,
   input  logic             i_bit,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_q
);
   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_diff;

   // Shift in the next dividend bit and subtract the divisor when it fits.
   always_comb begin
      w_shift = {i_rem, i_bit};
      // Only used when the subtraction succeeds, so the result is below 2^WIDTH.
      w_diff  = w_shift[WIDTH-1:0] - i_divisor;
      o_q     = (w_shift >= {1'b0, i_divisor});
      o_rem   = o_q ? w_diff : w_shift[WIDTH-1:0];
   end
endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (shift-add) / divide (restoring) unit.
module multdiv_unit
   import multdiv_pkg::*;
(
   input  logic     i_clk,
   input  logic     i_rst_n,
   multdiv_if.slave io_bus
);
   state_e             r_state;
   state_e             w_state_next;
   logic [CNT_W-1:0]   r_cnt;
   // MUL: shifted multiplicand. DIV: low half holds the dividend, MSB-first.
   logic [2*WIDTH-1:0] r_opa;
   // MUL: multiplier, LSB-first. DIV: divisor magnitude.
   logic [WIDTH-1:0]   r_opb;
   // MUL: partial product. DIV: {remainder, quotient}.
   logic [2*WIDTH-1:0] r_acc;
   logic               r_neg;
   logic               r_div_zero;
   logic               r_div_ovf;
   logic [WIDTH-1:0]   r_result;
   logic               r_exception;

   logic               w_last;
   logic [2*WIDTH-1:0] w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_prod;
   logic               w_mul_ovf;
   logic [WIDTH-1:0]   w_div_rem;
   logic               w_div_q;
   logic [WIDTH-1:0]   w_quot_mag;
   logic [WIDTH-1:0]   w_quot;

   multdiv_div_step u_div_step (
      .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
      .i_divisor (r_opb),
      .i_bit     (r_opa[WIDTH-1]),
      .o_rem     (w_div_rem),
      .o_q       (w_div_q)
   );

   // Iteration arithmetic and final sign/exception shaping.
   always_comb begin
      w_last     = (r_cnt == CNT_W'(WIDTH - 1));
      w_mul_sum  = r_acc + (r_opb[0] ? r_opa : '0);
      w_mul_prod = r_neg ? (~w_mul_sum + 1'b1) : w_mul_sum;
      // Fits in signed WIDTH only if bits [2W-1:W-1] are all equal.
      w_mul_ovf  = !((&w_mul_prod[2*WIDTH-1:WIDTH-1]) || !(|w_mul_prod[2*WIDTH-1:WIDTH-1]));
      w_quot_mag = {r_acc[WIDTH-2:0], w_div_q};
      w_quot     = r_neg ? (~w_quot_mag + 1'b1) : w_quot_mag;
   end

   // Next-state decode; MULT has priority, starts outside IDLE are dropped.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (io_bus.ctrl_MULT)     w_state_next = MUL;
            else if (io_bus.ctrl_DIV) w_state_next = DIV;
         end
         MUL, DIV: if (w_last) w_state_next = DONE;
         DONE:     w_state_next = IDLE;
         default:  w_state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   // Operand latch, per-cycle iteration and result write-back.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt       <= '0;
         r_opa       <= '0;
         r_opb       <= '0;
         r_acc       <= '0;
         r_neg       <= 1'b0;
         r_div_zero  <= 1'b0;
         r_div_ovf   <= 1'b0;
         r_result    <= '0;
         r_exception <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (io_bus.ctrl_MULT || io_bus.ctrl_DIV) begin
                  r_cnt      <= '0;
                  r_opa      <= {{WIDTH{1'b0}}, f_abs(io_bus.data_operandA)};
                  r_opb      <= f_abs(io_bus.data_operandB);
                  r_acc      <= '0;
                  r_neg      <= io_bus.data_operandA[WIDTH-1] ^ io_bus.data_operandB[WIDTH-1];
                  r_div_zero <= (io_bus.data_operandB == '0);
                  r_div_ovf  <= (io_bus.data_operandA == INT_MIN) && (&io_bus.data_operandB);
               end
            end
            MUL: begin
               r_cnt <= r_cnt + 1'b1;
               r_acc <= w_mul_sum;
               r_opa <= r_opa << 1;
               r_opb <= r_opb >> 1;
               if (w_last) begin
                  r_result    <= w_mul_prod[WIDTH-1:0];
                  r_exception <= w_mul_ovf;
               end
            end
            DIV: begin
               r_cnt <= r_cnt + 1'b1;
               r_acc <= {w_div_rem, r_acc[WIDTH-2:0], w_div_q};
               r_opa <= r_opa << 1;
               if (w_last) begin
                  r_result    <= r_div_zero ? '0 : w_quot;
                  r_exception <= r_div_zero | r_div_ovf;
               end
            end
            default: ;
         endcase
      end
   end

   assign io_bus.data_result    = r_result;
   assign io_bus.data_exception = r_exception;
   assign io_bus.data_resultRDY = (r_state == DONE);
   assign io_bus.busy           = (r_state != IDLE);
endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed table, corner sequences, random vs model.
module tb_multdiv_unit;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   multdiv_if bus ();

   multdiv_unit dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        is_div;
      logic [31:0] exp_res;
      logic        exp_exc;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain signed arithmetic on the architectural values.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 input logic is_div, output logic [31:0] r, output logic e);
      longint p;
      if (!is_div) begin
         p = longint'($signed(a)) * longint'($signed(b));
         r = p[31:0];
         e = (p != longint'($signed(r)));
      end else if (b == 32'd0) begin
         r = 32'd0;
         e = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r = 32'h8000_0000;
         e = 1'b1;
      end else begin
         r = 32'($signed(a) / $signed(b));
         e = 1'b0;
      end
   endfunction

   // Issue one op, scramble operands after the start edge, wait for RDY (bounded).
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic is_div,
                         output logic [31:0] res, output logic exc, output int lat,
                         output int busy_bad, output logic rdy_after);
      @(negedge clk);
      bus.data_operandA = a;
      bus.data_operandB = b;
      bus.ctrl_MULT     = !is_div;
      bus.ctrl_DIV      = is_div;
      @(posedge clk);
      #1;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
      lat      = -1;
      busy_bad = 0;
      res      = '0;
      exc      = 1'b0;
      if (!bus.busy) busy_bad++;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (!bus.busy) busy_bad++;
         if (bus.data_resultRDY) begin
            lat = i;
            res = bus.data_result;
            exc = bus.data_exception;
            break;
         end
      end
      @(posedge clk);
      #1;
      rdy_after = bus.data_resultRDY;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[8];
      logic [31:0] res;
      logic [31:0] er;
      logic        exc;
      logic        ee;
      logic        rdy_after;
      int          lat;
      int          busy_bad;
      int          rdy_cnt;
      int          rdy_lat;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] tmp;

      n_checks = 0;
      n_errors = 0;

      vecs[0] = '{32'd7,          32'hFFFF_FFFA, 1'b0, 32'hFFFF_FFD6, 1'b0};
      vecs[1] = '{32'h0001_0000,  32'h0001_0000, 1'b0, 32'h0000_0000, 1'b1};
      vecs[2] = '{32'h8000_0000,  32'd1,         1'b0, 32'h8000_0000, 1'b0};
      vecs[3] = '{32'hFFFF_FFF9,  32'd2,         1'b1, 32'hFFFF_FFFD, 1'b0};
      vecs[4] = '{32'd100,        32'd7,         1'b1, 32'd14,        1'b0};
      vecs[5] = '{32'd1234,       32'd0,         1'b1, 32'd0,         1'b1};
      vecs[6] = '{32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1};
      vecs[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 32'd1,         1'b0};

      rst_n             = 1'b0;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_result", 64'(bus.data_result), 64'd0);
      check("reset_exc",    64'(bus.data_exception), 64'd0);
      check("reset_rdy",    64'(bus.data_resultRDY), 64'd0);
      check("reset_busy",   64'(bus.busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].is_div, res, exc, lat, busy_bad, rdy_after);
         check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp_res));
         check($sformatf("vec%0d_exc", i), 64'(exc), 64'(vecs[i].exp_exc));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
         check($sformatf("vec%0d_busy", i), 64'(busy_bad), 64'd0);
         check($sformatf("vec%0d_rdy_pulse", i), 64'(rdy_after), 64'd0);
      end

      // Both starts together (MULT wins); a DIV pulse mid-operation is dropped.
      @(negedge clk);
      bus.data_operandA = 32'd3;
      bus.data_operandB = 32'd4;
      bus.ctrl_MULT     = 1'b1;
      bus.ctrl_DIV      = 1'b1;
      @(posedge clk);
      #1;
      bus.ctrl_MULT = 1'b0;
      bus.ctrl_DIV  = 1'b0;
      check("hold_on_start", 64'(bus.data_result), 64'd1);
      rdy_cnt = 0;
      rdy_lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.data_resultRDY) begin
            rdy_cnt++;
            if (rdy_lat < 0) rdy_lat = i;
         end
         bus.ctrl_DIV = (i == 9);
      end
      check("both_start_rdy_count", 64'(rdy_cnt), 64'd1);
      check("both_start_latency", 64'(rdy_lat), 64'd32);
      check("both_start_result", 64'(bus.data_result), 64'd12);
      check("both_start_exc", 64'(bus.data_exception), 64'd0);

      // Reset in cycle 15 of a divide: outputs clear at once, no RDY afterwards.
      @(negedge clk);
      bus.data_operandA = 32'd100;
      bus.data_operandB = 32'd7;
      bus.ctrl_DIV      = 1'b1;
      @(posedge clk);
      #1;
      bus.ctrl_DIV = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_result", 64'(bus.data_result), 64'd0);
      check("midrst_exc", 64'(bus.data_exception), 64'd0);
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_rdy", 64'(bus.data_resultRDY), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rdy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.data_resultRDY || bus.busy) rdy_cnt++;
      end
      check("midrst_no_rdy", 64'(rdy_cnt), 64'd0);
      run_op(32'd2, 32'd3, 1'b0, res, exc, lat, busy_bad, rdy_after);
      check("post_rst_result", 64'(res), 64'd6);
      check("post_rst_latency", 64'(lat), 64'd32);

      // Random operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            tmp = $urandom_range(0, 16);
            b   = tmp - 32'd8;
         end
         if ($urandom_range(0, 3) == 0) begin
            tmp = $urandom_range(0, 2000);
            a   = tmp - 32'd1000;
         end
         model(a, b, 1'(i % 2), er, ee);
         run_op(a, b, 1'(i % 2), res, exc, lat, busy_bad, rdy_after);
         check($sformatf("rnd%0d_result a=%0h b=%0h", i, a, b), 64'(res), 64'(er));
         check($sformatf("rnd%0d_exc", i), 64'(exc), 64'(ee));
         check($sformatf("rnd%0d_latency", i), 64'(lat), 64'd32);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
